// File: rtl/ppu_pkg.sv
// Shared PPU background definitions: fetch-state encodings,
// VRAM region constants and the fetch phase step condition.
package ppu_pkg;

  typedef enum logic [2:0] {
    ST_SLEEP  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_NT     = 3'd2,
    ST_AT     = 3'd3,
    ST_BG_LSB = 3'd4,
    ST_BG_MSB = 3'd5,
    ST_VBLANK = 3'd6
  } fetch_state_t;

  localparam logic [13:0] NT_BASE   = 14'h2000;
  localparam logic [13:0] AT_OFFSET = 14'h03C0;
  localparam logic [13:0] PT_STRIDE = 14'h1000;

  // x_rendercntr[2:0] value marking the last clk of a fetch phase
  localparam logic [2:0] BG_NEXT_STEP_CONDITION = 3'd3;

endpackage

// File: rtl/ppu_bg_fetch_pipe_if.sv
// VRAM read bus between the background fetch pipe
// and the VRAM arbiter.
interface ppu_bg_fetch_pipe_if;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_rdata;

  modport master (
    output vram_addr,
    output vram_rd,
    input  vram_rdata
  );

  modport slave (
    input  vram_addr,
    input  vram_rd,
    output vram_rdata
  );
endinterface

// File: rtl/ppu_bg_shifter16.sv
// 16-bit left shifter with parallel load of the low byte
// and a serial tap selected by fine horizontal scroll.
module ppu_bg_shifter16 (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic [2:0] fine_x,
  output logic       tap
);

  logic [15:0] sr;
  logic [15:0] shifted;

  assign shifted = shift ? {sr[14:0], 1'b0} : sr;

  // a same-clk load overwrites the low byte of the shifted value
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= {shifted[15:8], load_data};
    end else begin
      sr <= shifted;
    end
  end

  assign tap = sr[4'd15 - {1'b0, fine_x}];

endmodule

// File: rtl/ppu_bg_fetch_pipe.sv
// Background fetch datapath: VRAM address generation, tile
// latches, pattern/attribute shifters and pixel output.
module ppu_bg_fetch_pipe
  import ppu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          fetch_state,
  input  logic                step_strobe,
  input  logic                pix_strobe,
  input  logic [14:0]         v_addr,
  input  logic [2:0]          fine_x,
  input  logic                bg_pt_sel,
  input  logic                bg_enable,
  ppu_bg_fetch_pipe_if.master vram,
  output logic [3:0]          bg_pixel,
  output logic                coarse_x_inc,
  output logic                tile_loaded
);

  logic is_nt, is_at, is_lsb, is_msb, is_fetch;
  logic cap, reload, shift;
  logic [7:0]  nt_latch, lo_latch;
  logic [1:0]  at_latch;
  logic [2:0]  at_sh;
  logic [7:0]  at_byte;
  logic [13:0] pt_addr, addr_d, addr_q;
  logic        rd_q, load_q;
  logic [3:0]  pix_q;
  logic        tap_lo, tap_hi, tap_a0, tap_a1;

  // state 7 matches none of these and so acts as SLEEP
  assign is_nt    = fetch_state == ST_NT;
  assign is_at    = fetch_state == ST_AT;
  assign is_lsb   = fetch_state == ST_BG_LSB;
  assign is_msb   = fetch_state == ST_BG_MSB;
  assign is_fetch = is_nt | is_at | is_lsb | is_msb;

  assign cap    = step_strobe & bg_enable;
  assign reload = cap & is_msb;
  assign shift  = pix_strobe & bg_enable;

  assign at_sh   = {v_addr[6], v_addr[1], 1'b0};
  assign at_byte = vram.vram_rdata >> at_sh;

  assign pt_addr = (bg_pt_sel ? PT_STRIDE : 14'h0)
                 | {2'b0, nt_latch, 4'h0}
                 | {11'h0, v_addr[14:12]};

  always_comb begin
    addr_d = addr_q;
    unique case (1'b1)
      is_nt:   addr_d = NT_BASE | {2'b0, v_addr[11:0]};
      is_at:   addr_d = NT_BASE | AT_OFFSET
                      | {2'b0, v_addr[11:10], 10'h0}
                      | {8'h0, v_addr[9:7], 3'h0}
                      | {11'h0, v_addr[4:2]};
      is_lsb:  addr_d = pt_addr;
      is_msb:  addr_d = pt_addr | 14'd8;
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      rd_q     <= 1'b0;
      load_q   <= 1'b0;
      nt_latch <= '0;
      at_latch <= '0;
      lo_latch <= '0;
      pix_q    <= '0;
    end else begin
      addr_q <= addr_d;
      rd_q   <= is_fetch & bg_enable;
      load_q <= reload;
      if (cap & is_nt) nt_latch <= vram.vram_rdata;
      if (cap & is_at) at_latch <= at_byte[1:0];
      if (cap & is_lsb) lo_latch <= vram.vram_rdata;
      if (!bg_enable) begin
        pix_q <= '0;
      end else if (pix_strobe) begin
        pix_q <= {tap_a1, tap_a0, tap_hi, tap_lo};
      end
    end
  end

  ppu_bg_shifter16 u_pat_lo (
    .clk(clk), .rst(rst), .shift(shift), .load(reload),
    .load_data(lo_latch), .fine_x(fine_x), .tap(tap_lo)
  );

  ppu_bg_shifter16 u_pat_hi (
    .clk(clk), .rst(rst), .shift(shift), .load(reload),
    .load_data(vram.vram_rdata), .fine_x(fine_x), .tap(tap_hi)
  );

  ppu_bg_shifter16 u_attr0 (
    .clk(clk), .rst(rst), .shift(shift), .load(reload),
    .load_data({8{at_latch[0]}}), .fine_x(fine_x), .tap(tap_a0)
  );

  ppu_bg_shifter16 u_attr1 (
    .clk(clk), .rst(rst), .shift(shift), .load(reload),
    .load_data({8{at_latch[1]}}), .fine_x(fine_x), .tap(tap_a1)
  );

  assign vram.vram_addr = addr_q;
  assign vram.vram_rd   = rd_q;
  assign bg_pixel       = pix_q;
  assign tile_loaded    = load_q;
  assign coarse_x_inc   = load_q;

endmodule

// File: tb/tb_ppu_bg_fetch_pipe.sv
// Scoreboard bench for ppu_bg_fetch_pipe: directed tile fetches,
// expected addresses/pixels/reload pulses queued and checked by a monitor.
module tb_ppu_bg_fetch_pipe;
  import ppu_pkg::*;

  localparam logic [3:0] C1 = 4'hD;
  localparam logic [3:0] C2 = 4'hE;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fetch_state;
  logic        step_strobe;
  logic        pix_strobe;
  logic [14:0] v_addr;
  logic [2:0]  fine_x;
  logic        bg_pt_sel;
  logic        bg_enable;
  logic [3:0]  bg_pixel;
  logic        coarse_x_inc;
  logic        tile_loaded;

  int checks = 0;
  int failures = 0;

  logic [13:0] addr_exp [$];
  logic [3:0]  pix_exp [$];
  logic        tl_exp [$];
  logic [3:0]  fs [8];

  logic pix_seen = 1'b0;
  logic step_seen = 1'b0;

  always #20 clk = ~clk;

  ppu_bg_fetch_pipe_if vif ();

  ppu_bg_fetch_pipe dut (
    .clk(clk),
    .rst(rst),
    .fetch_state(fetch_state),
    .step_strobe(step_strobe),
    .pix_strobe(pix_strobe),
    .v_addr(v_addr),
    .fine_x(fine_x),
    .bg_pt_sel(bg_pt_sel),
    .bg_enable(bg_enable),
    .vram(vif),
    .bg_pixel(bg_pixel),
    .coarse_x_inc(coarse_x_inc),
    .tile_loaded(tile_loaded)
  );

  always @(posedge clk) begin
    pix_seen  <= pix_strobe;
    step_seen <= step_strobe;
  end

  // monitor: pops expectations whenever the DUT presents a result
  always @(negedge clk) begin
    logic [3:0]  ep;
    logic [13:0] ea;
    if (pix_seen) begin
      checks++;
      if (pix_exp.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected got=%h", bg_pixel);
      end else begin
        ep = pix_exp.pop_front();
        if (bg_pixel !== ep) begin
          failures++;
          $display("FAIL bg_pixel got=%h exp=%h", bg_pixel, ep);
        end
      end
    end
    if (step_seen) begin
      checks++;
      if (addr_exp.size() == 0) begin
        failures++;
        $display("FAIL addr_unexpected got=%h", vif.vram_addr);
      end else begin
        ea = addr_exp.pop_front();
        if (vif.vram_addr !== ea || vif.vram_rd !== 1'b1) begin
          failures++;
          $display("FAIL vram_addr got=%h rd=%b exp=%h rd=1",
                   vif.vram_addr, vif.vram_rd, ea);
        end
      end
    end
    if (tile_loaded || coarse_x_inc) begin
      checks++;
      if (tl_exp.size() == 0 || tile_loaded !== 1'b1 || coarse_x_inc !== 1'b1) begin
        failures++;
        $display("FAIL reload_pulse got tl=%b cxi=%b pending=%0d exp tl=1 cxi=1",
                 tile_loaded, coarse_x_inc, tl_exp.size());
      end else begin
        void'(tl_exp.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic run_phase(input logic [2:0] st, input logic [7:0] d,
                           input logic [13:0] a, input logic pl,
                           input logic [3:0] pe);
    fetch_state = st;
    vif.vram_rdata = d;
    for (int i = 0; i < 8; i++) begin
      step_strobe = (i == 7);
      pix_strobe = pl && (i == 7);
      if (i == 7) begin
        addr_exp.push_back(a);
        if (pl) pix_exp.push_back(pe);
        if (st == ST_BG_MSB) tl_exp.push_back(1'b1);
      end
      @(posedge clk);
      #1;
    end
    step_strobe = 1'b0;
    pix_strobe = 1'b0;
    fetch_state = ST_IDLE;
  endtask

  task automatic fetch_tile(input logic [7:0] nt, input logic [7:0] at,
                            input logic [7:0] lo, input logic [7:0] hi,
                            input logic [13:0] a_nt, input logic [13:0] a_at,
                            input logic [13:0] a_lo, input logic [13:0] a_hi,
                            input logic pl, input logic [3:0] pe);
    run_phase(ST_NT, nt, a_nt, 1'b0, 4'h0);
    run_phase(ST_AT, at, a_at, 1'b0, 4'h0);
    run_phase(ST_BG_LSB, lo, a_lo, 1'b0, 4'h0);
    run_phase(ST_BG_MSB, hi, a_hi, pl, pe);
  endtask

  task automatic strobe(input logic [3:0] e);
    pix_strobe = 1'b1;
    pix_exp.push_back(e);
    @(posedge clk);
    #1;
    pix_strobe = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fetch_state = ST_IDLE;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fetch_state = ST_SLEEP;
    step_strobe = 1'b0;
    pix_strobe = 1'b0;
    v_addr = '0;
    fine_x = '0;
    bg_pt_sel = 1'b0;
    bg_enable = 1'b1;
    vif.vram_rdata = '0;
    fs = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0};

    repeat (3) @(negedge clk);
    chk("rst_vram_addr", {2'b0, vif.vram_addr}, 16'h0000);
    chk("rst_vram_rd", {15'b0, vif.vram_rd}, 16'h0000);
    chk("rst_bg_pixel", {12'b0, bg_pixel}, 16'h0000);
    chk("rst_pulses", {14'b0, tile_loaded, coarse_x_inc}, 16'h0000);
    rst = 1'b0;
    #1;

    // address generation
    v_addr = 15'h7ABC;
    bg_pt_sel = 1'b1;
    fetch_tile(8'h5A, 8'hE4, 8'h00, 8'h00,
               14'h2ABC, 14'h2BEF, 14'h15A7, 14'h15AF, 1'b0, 4'h0);
    bg_pt_sel = 1'b0;

    // attribute quadrant (v6,v1)=(1,0) -> palette 2
    do_reset();
    v_addr = 15'h0040;
    fetch_tile(8'h00, 8'hE4, 8'hFF, 8'h00,
               14'h2040, 14'h23C0, 14'h0000, 14'h0008, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) strobe(4'h0);
    strobe(4'h9);

    // attribute quadrant (v6,v1)=(0,1) -> palette 1
    do_reset();
    v_addr = 15'h0002;
    fetch_tile(8'h00, 8'hE4, 8'hFF, 8'h00,
               14'h2002, 14'h23C0, 14'h0000, 14'h0008, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) strobe(4'h0);
    strobe(4'h5);

    // pixel output with a disable window in the middle
    do_reset();
    v_addr = 15'h0000;
    fetch_tile(8'h11, 8'hFF, 8'hF0, 8'h0F,
               14'h2000, 14'h23C0, 14'h0110, 14'h0118, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) strobe(4'h0);
    strobe(C1);
    strobe(C1);
    bg_enable = 1'b0;
    fetch_state = ST_NT;
    for (int i = 0; i < 3; i++) strobe(4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("dis_vram_rd", {15'b0, vif.vram_rd}, 16'h0000);
    chk("dis_bg_pixel", {12'b0, bg_pixel}, 16'h0000);
    fetch_state = ST_IDLE;
    bg_enable = 1'b1;
    strobe(C1);
    strobe(C1);
    for (int i = 0; i < 4; i++) strobe(C2);

    // reset in the middle of BG_LSB
    run_phase(ST_NT, 8'h22, 14'h2000, 1'b0, 4'h0);
    run_phase(ST_AT, 8'h00, 14'h23C0, 1'b0, 4'h0);
    fetch_state = ST_BG_LSB;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_vram_rd", {15'b0, vif.vram_rd}, 16'h0001);
    chk("pre_rst_bg_pixel", {12'b0, bg_pixel}, {12'b0, C2});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vram_rd", {15'b0, vif.vram_rd}, 16'h0000);
    chk("mid_rst_bg_pixel", {12'b0, bg_pixel}, 16'h0000);
    rst = 1'b0;
    fetch_state = ST_IDLE;
    #1;

    // same-clk shift and reload: 8001 -> 00AA
    do_reset();
    fetch_tile(8'h01, 8'h00, 8'h80, 8'h00,
               14'h2000, 14'h23C0, 14'h0010, 14'h0018, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) strobe(4'h0);
    fetch_tile(8'h02, 8'h00, 8'h01, 8'h00,
               14'h2000, 14'h23C0, 14'h0020, 14'h0028, 1'b0, 4'h0);
    fetch_tile(8'h03, 8'h00, 8'hAA, 8'h55,
               14'h2000, 14'h23C0, 14'h0030, 14'h0038, 1'b1, 4'h1);
    for (int i = 0; i < 8; i++) strobe(4'h0);
    for (int i = 0; i < 8; i++) strobe((i % 2 == 0) ? 4'h1 : 4'h2);

    // fine scroll of 3 across two preloaded tiles
    do_reset();
    fetch_tile(8'h04, 8'h00, 8'h10, 8'h00,
               14'h2000, 14'h23C0, 14'h0040, 14'h0048, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) strobe(4'h0);
    fetch_tile(8'h05, 8'h00, 8'h80, 8'h40,
               14'h2000, 14'h23C0, 14'h0050, 14'h0058, 1'b0, 4'h0);
    fine_x = 3'd3;
    for (int i = 0; i < 8; i++) strobe(fs[i]);
    fine_x = 3'd0;

    repeat (3) @(negedge clk);
    chk("pix_queue_drained", pix_exp.size(), 16'h0000);
    chk("addr_queue_drained", addr_exp.size(), 16'h0000);
    chk("reload_queue_drained", tl_exp.size(), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_bg_fetch_pipe.md
Name: ppu_bg_fetch_pipe

Overview:
- Background datapath stage directly downstream of the PPU background rendering state machine.
- Consumes its fetch state (NT/AT/BG_LSB/BG_MSB) and 8-clock phase strobes.
- Generates VRAM read addresses and latches returned bytes into tile latches, then 16-bit pattern/attribute shift registers.
- Emits one 4-bit background colour index per pixel strobe to the pixel mux/palette stage.

Parameters:
- NT_BASE, 14'h2000, nametable region base address.
- AT_OFFSET, 14'h03C0, attribute table offset inside each nametable.
- PT_STRIDE, 14'h1000, pattern-table half size; selected by bg_pt_sel.

Ports:
- clk  in  1  25 MHz PPU clock
- rst  in  1  synchronous, active-high reset
- fetch_state  in  3  FSM state: 0 SLEEP, 1 IDLE, 2 NT, 3 AT, 4 BG_LSB, 5 BG_MSB, 6 VBLANK
- step_strobe  in  1  last clk of current 8-clk fetch phase (x_rendercntr[2:0]==3)
- pix_strobe  in  1  one pulse per output pixel; shift enable
- v_addr  in  15  loopy v: fine_y[14:12], nt[11:10], coarse_y[9:5], coarse_x[4:0]
- fine_x  in  3  fine horizontal scroll
- bg_pt_sel  in  1  PPUCTRL bit 4, background pattern table select
- bg_enable  in  1  PPUMASK background enable
- vram_rdata  in  8  VRAM read data; valid ≤6 clks after vram_rd rises
- vram_addr  out  14  VRAM read address
- vram_rd  out  1  read request, high for a full fetch phase
- bg_pixel  out  4  {palette[1:0], pattern[1:0]}; 0 = transparent
- coarse_x_inc  out  1  1-clk pulse to scroll unit after each tile completes
- tile_loaded  out  1  1-clk pulse when shifters reload

Behaviour:
- Reset values: all outputs 0, all latches 0, all shifters 0.
- vram_addr is registered and updated one clk after fetch_state changes.
- Address for each fetch state:
  - NT: NT_BASE | v[11:0].
  - AT: NT_BASE | AT_OFFSET | v[11:10]<<10 | v[9:7]<<3 | v[4:2].
  - BG_LSB: bg_pt_sel*PT_STRIDE | nt_latch<<4 | v[14:12].
  - BG_MSB: the BG_LSB address + 8.
- vram_rd is 1 while the registered fetch state is NT/AT/BG_LSB/BG_MSB. It is 0 in SLEEP/IDLE/VBLANK and whenever bg_enable=0.
- Data capture happens on step_strobe, into the latch selected by fetch_state:
  - NT → nt_latch.
  - AT → at_latch = attribute byte >> {v[6],v[1],1'b0}, low 2 bits kept.
  - BG_LSB → lo_latch.
  - BG_MSB → hi_latch.
- Consecutive NT states (first/last NT dummy fetches) simply overwrite nt_latch. No reload occurs.
- Reload happens on step_strobe while fetch_state==BG_MSB. The low byte of pat_lo_sr/pat_hi_sr takes lo_latch/vram_rdata. The low byte of attr0_sr/attr1_sr takes {8{at_latch[0]}}/{8{at_latch[1]}}. tile_loaded and coarse_x_inc pulse the following clk.
- Shift on pix_strobe: all four 16-bit registers shift left by 1, with 0 inserted.
- Shift and reload in the same clk: result = {shifted[15:8], new byte}. The shift is applied first, then the low byte is replaced.
- bg_pixel is registered on pix_strobe: {attr1[15-fine_x], attr0[15-fine_x], hi[15-fine_x], lo[15-fine_x]}. It holds between strobes and is forced to 0 when bg_enable=0.
- fine_x changes take effect at the next pix_strobe. There is no pipeline flush.
- Illegal fetch_state (7) behaves as SLEEP.
- Reset mid-line clears everything. Output resumes cleanly after two full tile fetches.
- bg_enable=0 freezes the latches and shifters. Its deassertion does not clear them.

Decomposition:
- Shared package ppu_pkg holds:
  - fetch-state encodings, shared with ppu_rendering_FSM;
  - NT_BASE, AT_OFFSET, PT_STRIDE;
  - BG_NEXT_STEP_CONDITION.
- One sub-module, ppu_bg_shifter16: 16-bit shift/parallel-low-load register with serial tap select by fine_x. It is instantiated four times (pattern lo/hi, attribute 0/1).

Test Plan:
- Address generation: v_addr=15'h7ABC, bg_pt_sel=1, NT read returns 8'h5A.
  - NT phase → vram_addr=14'h2ABC.
  - AT phase → 14'h2BEF.
  - BG_LSB → 14'h15A7.
  - BG_MSB → 14'h15AF.
- Attribute quadrant: attribute byte 8'b11_10_01_00 with (v[6],v[1])=(1,0) → at_latch=2'b10. With (0,1) → at_latch=2'b01.
- Pixel output: load lo=8'hF0, hi=8'h0F, at=2'b11 into an empty pipe, fine_x=0. Apply 8 pix_strobes to bring the tile up, then 8 more → bg_pixel sequence C1,C1,C1,C1,C2,C2,C2,C2.
- Same-clk shift+reload: sr=16'h8001, pix_strobe and reload of 8'hAA together → sr=16'h00AA. tile_loaded and coarse_x_inc each pulse exactly 1 clk.
- Fine scroll: fine_x=3 with two preloaded tiles → first bg_pixel equals bit 12 of the shifters, i.e. 3-pixel offset.
- Reset/disable:
  - rst asserted mid BG_LSB → vram_rd=0, bg_pixel=0 next clk.
  - bg_enable=0 → vram_rd=0 and bg_pixel=0 while shifters stay frozen.
